mem_port_arbiter: RTL and testbench

- Shares the single 512-byte unified memory port (9-bit byte address, 32-bit data, 4-bit write strobe) between the core's instruction-fetch requester and its load/store requester.
- Arbitrates between the two requesters and sequences one memory transaction at a time using a valid/ready handshake.
- Rejects misaligned accesses and recovers from a memory that never responds.
- Sits between the pipeline stages and the memory model; drives the mem_instr/mem_addr/mem_wdata/mem_wstrb bus.

---
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one 512-byte memory port between instruction fetch (I) and load/store (D).
// Runs one transaction at a time; rejects misaligned accesses and aborts on a stalled memory.
module mem_port_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [8:0]  i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_valid,
  input  logic [8:0]  d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a requester holds *_valid until it owns the port; *_ready is a
  // one-cycle completion pulse (err/rdata qualified by it), never backpressure.
  // Toward memory, mem_valid and the whole bus stay stable until mem_ready is sampled.

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_owner_d, w_owner_d_nxt;
  logic          r_last_d, w_last_d_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic          r_mem_valid, w_mem_valid_nxt;
  logic          r_mem_instr, w_mem_instr_nxt;
  logic [8:0]    r_mem_addr, w_mem_addr_nxt;
  logic [31:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]    r_mem_wstrb, w_mem_wstrb_nxt;

  logic          r_i_ready, w_i_ready_nxt;
  logic          r_i_err, w_i_err_nxt;
  logic [31:0]   r_i_rdata, w_i_rdata_nxt;
  logic          r_d_ready, w_d_ready_nxt;
  logic          r_d_err, w_d_err_nxt;
  logic [31:0]   r_d_rdata, w_d_rdata_nxt;

  logic          w_any_req;
  logic          w_grant_d;
  logic [8:0]    w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic [3:0]    w_sel_wstrb;
  logic [CW-1:0] w_cnt_inc;
  logic          w_timeout;
  logic          w_pulse;
  logic          w_pulse_err;
  logic [31:0]   w_pulse_data;

  assign w_any_req = i_valid | d_valid;

  // Round-robin hands a contended grant to whoever did not win last time.
  always_comb begin
    if (ARB_MODE == 1) begin
      w_grant_d = d_valid;
    end else if (i_valid && d_valid) begin
      w_grant_d = ~r_last_d;
    end else begin
      w_grant_d = d_valid;
    end
  end

  assign w_sel_addr  = w_grant_d ? d_addr  : i_addr;
  assign w_sel_wdata = w_grant_d ? d_wdata : 32'h0;
  assign w_sel_wstrb = w_grant_d ? d_wstrb : 4'h0;

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT > 0) && (w_cnt_inc == TO_VAL);

  always_comb begin
    w_state_nxt     = r_state;
    w_owner_d_nxt   = r_owner_d;
    w_last_d_nxt    = r_last_d;
    w_cnt_nxt       = r_cnt;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_instr_nxt = r_mem_instr;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wstrb_nxt = r_mem_wstrb;
    w_pulse         = 1'b0;
    w_pulse_err     = 1'b0;
    w_pulse_data    = 32'h0;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_owner_d_nxt   = w_grant_d;
          w_last_d_nxt    = w_grant_d;
          w_mem_addr_nxt  = w_sel_addr;
          w_mem_wdata_nxt = w_sel_wdata;
          w_mem_wstrb_nxt = w_sel_wstrb;
          w_cnt_nxt       = '0;
          if (w_sel_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error without touching memory.
            w_state_nxt = S_ERR;
            w_pulse     = 1'b1;
            w_pulse_err = 1'b1;
          end else begin
            w_state_nxt     = S_BUSY;
            w_mem_valid_nxt = 1'b1;
            w_mem_instr_nxt = ~w_grant_d;
          end
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          w_state_nxt     = S_DONE;
          w_mem_valid_nxt = 1'b0;
          w_pulse         = 1'b1;
          w_pulse_data    = mem_rdata;
        end else if (w_timeout) begin
          w_state_nxt     = S_DONE;
          w_mem_valid_nxt = 1'b0;
          w_cnt_nxt       = w_cnt_inc;
          w_pulse         = 1'b1;
          w_pulse_err     = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DONE, S_ERR: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_i_ready_nxt = w_pulse & ~w_owner_d_nxt;
    w_i_err_nxt   = w_pulse & w_pulse_err & ~w_owner_d_nxt;
    w_i_rdata_nxt = (w_pulse && !w_owner_d_nxt) ? w_pulse_data : r_i_rdata;
    w_d_ready_nxt = w_pulse & w_owner_d_nxt;
    w_d_err_nxt   = w_pulse & w_pulse_err & w_owner_d_nxt;
    w_d_rdata_nxt = (w_pulse && w_owner_d_nxt) ? w_pulse_data : r_d_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner_d   <= 1'b0;
      r_last_d    <= 1'b1;
      r_cnt       <= '0;
      r_mem_valid <= 1'b0;
      r_mem_instr <= 1'b0;
      r_mem_addr  <= 9'h0;
      r_mem_wdata <= 32'h0;
      r_mem_wstrb <= 4'h0;
      r_i_ready   <= 1'b0;
      r_i_err     <= 1'b0;
      r_i_rdata   <= 32'h0;
      r_d_ready   <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner_d   <= w_owner_d_nxt;
      r_last_d    <= w_last_d_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_instr <= w_mem_instr_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wstrb <= w_mem_wstrb_nxt;
      r_i_ready   <= w_i_ready_nxt;
      r_i_err     <= w_i_err_nxt;
      r_i_rdata   <= w_i_rdata_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_d_err     <= w_d_err_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

  assign i_ready     = r_i_ready;
  assign i_err       = r_i_err;
  assign i_rdata     = r_i_rdata;
  assign d_ready     = r_d_ready;
  assign d_err       = r_d_err;
  assign d_rdata     = r_d_rdata;
  assign mem_valid   = r_mem_valid;
  assign mem_instr   = r_mem_instr;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrb   = r_mem_wstrb;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a D-priority instance share the requester
// inputs, each with its own memory responder and transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_valid, d_valid;
  logic [8:0]  i_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;

  logic        dut_i_ready   [2];
  logic [31:0] dut_i_rdata   [2];
  logic        dut_i_err     [2];
  logic        dut_d_ready   [2];
  logic [31:0] dut_d_rdata   [2];
  logic        dut_d_err     [2];
  logic        dut_mem_valid [2];
  logic        dut_mem_instr [2];
  logic [8:0]  dut_mem_addr  [2];
  logic [31:0] dut_mem_wdata [2];
  logic [3:0]  dut_mem_wstrb [2];
  logic        dut_mem_ready [2];
  logic [31:0] dut_mem_rdata [2];
  logic [1:0]  dut_dbg_state [2];

  mem_port_arbiter #(.ARB_MODE(0), .TIMEOUT(TIMEOUT)) u_dut_rr (
    .clk(clk), .reset(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(dut_i_ready[0]), .i_rdata(dut_i_rdata[0]), .i_err(dut_i_err[0]),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(dut_d_ready[0]), .d_rdata(dut_d_rdata[0]), .d_err(dut_d_err[0]),
    .mem_valid(dut_mem_valid[0]), .mem_instr(dut_mem_instr[0]), .mem_addr(dut_mem_addr[0]),
    .mem_wdata(dut_mem_wdata[0]), .mem_wstrb(dut_mem_wstrb[0]),
    .mem_ready(dut_mem_ready[0]), .mem_rdata(dut_mem_rdata[0]), .o_dbg_state(dut_dbg_state[0])
  );

  mem_port_arbiter #(.ARB_MODE(1), .TIMEOUT(TIMEOUT)) u_dut_pri (
    .clk(clk), .reset(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(dut_i_ready[1]), .i_rdata(dut_i_rdata[1]), .i_err(dut_i_err[1]),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(dut_d_ready[1]), .d_rdata(dut_d_rdata[1]), .d_err(dut_d_err[1]),
    .mem_valid(dut_mem_valid[1]), .mem_instr(dut_mem_instr[1]), .mem_addr(dut_mem_addr[1]),
    .mem_wdata(dut_mem_wdata[1]), .mem_wstrb(dut_mem_wstrb[1]),
    .mem_ready(dut_mem_ready[1]), .mem_rdata(dut_mem_rdata[1]), .o_dbg_state(dut_dbg_state[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] mem_words [128];
  int lat [2];
  int rcnt [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || !dut_mem_valid[k] || dut_mem_ready[k] === 1'b1) begin
        dut_mem_ready[k] = 1'b0;
        dut_mem_rdata[k] = 32'h0;
        rcnt[k] = 0;
      end else begin
        rcnt[k]++;
        if (lat[k] != 0 && rcnt[k] == lat[k]) begin
          dut_mem_ready[k] = 1'b1;
          dut_mem_rdata[k] = mem_words[dut_mem_addr[k][8:2]];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Per instance: busy = a memory request is outstanding, pulse = this cycle is
  // the completion cycle. Nothing new is accepted during a pulse cycle.
  bit          m_busy [2];
  bit          m_pulse [2];
  bit          m_err [2];
  bit          m_owner_d [2];
  bit          m_last_d [2];
  int          m_wait [2];
  logic [31:0] m_rdata [2];
  logic [8:0]  m_addr [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wstrb [2];

  task automatic model_step(input int k);
    bit pick_d;
    logic [8:0] a;
    if (m_pulse[k]) begin
      m_pulse[k] = 1'b0;
    end else if (m_busy[k]) begin
      if (dut_mem_ready[k] === 1'b1) begin
        m_busy[k] = 1'b0; m_pulse[k] = 1'b1; m_err[k] = 1'b0; m_rdata[k] = dut_mem_rdata[k];
      end else begin
        m_wait[k]++;
        if (TIMEOUT > 0 && m_wait[k] >= TIMEOUT) begin
          m_busy[k] = 1'b0; m_pulse[k] = 1'b1; m_err[k] = 1'b1; m_rdata[k] = 32'h0;
        end
      end
    end else if (i_valid || d_valid) begin
      if (k == 1) pick_d = d_valid;
      else if (i_valid && d_valid) pick_d = !m_last_d[k];
      else pick_d = d_valid;
      m_last_d[k]  = pick_d;
      m_owner_d[k] = pick_d;
      a = pick_d ? d_addr : i_addr;
      m_addr[k]  = a;
      m_wdata[k] = pick_d ? d_wdata : 32'h0;
      m_wstrb[k] = pick_d ? d_wstrb : 4'h0;
      if (a % 4 != 0) begin
        m_pulse[k] = 1'b1; m_err[k] = 1'b1; m_rdata[k] = 32'h0;
      end else begin
        m_busy[k] = 1'b1; m_wait[k] = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0; m_pulse[k] = 1'b0; m_err[k] = 1'b0; m_owner_d[k] = 1'b0;
        m_last_d[k] = 1'b1; m_wait[k] = 0; m_rdata[k] = 32'h0;
        m_addr[k] = 9'h0; m_wdata[k] = 32'h0; m_wstrb[k] = 4'h0;
      end else begin
        model_step(k);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d mem_valid", k), 32'(dut_mem_valid[k]), 32'(m_busy[k]));
      check($sformatf("dut%0d i_ready", k), 32'(dut_i_ready[k]), 32'(m_pulse[k] && !m_owner_d[k]));
      check($sformatf("dut%0d d_ready", k), 32'(dut_d_ready[k]), 32'(m_pulse[k] && m_owner_d[k]));
      check($sformatf("dut%0d i_err", k), 32'(dut_i_err[k]), 32'(m_pulse[k] && !m_owner_d[k] && m_err[k]));
      check($sformatf("dut%0d d_err", k), 32'(dut_d_err[k]), 32'(m_pulse[k] && m_owner_d[k] && m_err[k]));
      check($sformatf("dut%0d ready_excl", k), 32'(dut_i_ready[k] & dut_d_ready[k]), 32'h0);
      if (m_busy[k]) begin
        check($sformatf("dut%0d mem_instr", k), 32'(dut_mem_instr[k]), 32'(!m_owner_d[k]));
        check($sformatf("dut%0d mem_addr", k), 32'(dut_mem_addr[k]), 32'(m_addr[k]));
        check($sformatf("dut%0d mem_wdata", k), dut_mem_wdata[k], m_wdata[k]);
        check($sformatf("dut%0d mem_wstrb", k), 32'(dut_mem_wstrb[k]), 32'(m_wstrb[k]));
      end
      if (m_pulse[k]) begin
        check($sformatf("dut%0d rdata", k), m_owner_d[k] ? dut_d_rdata[k] : dut_i_rdata[k], m_rdata[k]);
      end
    end
  end

  // ---------------- grant monitor / scoreboard ----------------
  logic [0:0] exp_q [$];
  logic       got_q0 [$];
  logic       got_q1 [$];
  bit         log_en = 1'b0;
  bit         prev_mv [2];

  always @(negedge clk) begin
    if (log_en && dut_mem_valid[0] && !prev_mv[0]) got_q0.push_back(dut_mem_instr[0]);
    if (log_en && dut_mem_valid[1] && !prev_mv[1]) got_q1.push_back(dut_mem_instr[1]);
    prev_mv[0] = dut_mem_valid[0];
    prev_mv[1] = dut_mem_valid[1];
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s dut%0d mem_valid", tag, k), 32'(dut_mem_valid[k]), 32'h0);
      check($sformatf("%s dut%0d readys", tag, k), 32'({dut_i_ready[k], dut_d_ready[k]}), 32'h0);
      check($sformatf("%s dut%0d errs", tag, k), 32'({dut_i_err[k], dut_d_err[k]}), 32'h0);
      check($sformatf("%s dut%0d i_rdata", tag, k), dut_i_rdata[k], 32'h0);
      check($sformatf("%s dut%0d d_rdata", tag, k), dut_d_rdata[k], 32'h0);
      check($sformatf("%s dut%0d bus", tag, k),
            32'({dut_mem_instr[k], dut_mem_addr[k], dut_mem_wstrb[k]}), 32'h0);
      check($sformatf("%s dut%0d mem_wdata", tag, k), dut_mem_wdata[k], 32'h0);
    end
  endtask

  // Issue one request (held one cycle) and follow instance 0 until its ready pulse.
  task automatic do_req(input bit is_d, input logic [8:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        output logic b_mv, output logic b_instr, output logic [8:0] b_addr,
                        output logic [31:0] b_wdata, output logic [3:0] b_wstrb, output int mv_cnt,
                        output logic got_i, output logic got_d, output logic err, output logic [31:0] rdata);
    if (is_d) begin
      d_valid = 1'b1; d_addr = addr; d_wdata = wd; d_wstrb = ws;
    end else begin
      i_valid = 1'b1; i_addr = addr;
    end
    mv_cnt = 0; got_i = 1'b0; got_d = 1'b0; err = 1'b0; rdata = 32'h0;
    b_mv = 1'b0; b_instr = 1'b0; b_addr = 9'h0; b_wdata = 32'h0; b_wstrb = 4'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        i_valid = 1'b0; d_valid = 1'b0;
        b_mv = dut_mem_valid[0]; b_instr = dut_mem_instr[0]; b_addr = dut_mem_addr[0];
        b_wdata = dut_mem_wdata[0]; b_wstrb = dut_mem_wstrb[0];
      end
      if (dut_mem_valid[0]) mv_cnt++;
      if (dut_i_ready[0] || dut_d_ready[0]) begin
        got_i = dut_i_ready[0]; got_d = dut_d_ready[0];
        err   = got_i ? dut_i_err[0] : dut_d_err[0];
        rdata = got_i ? dut_i_rdata[0] : dut_d_rdata[0];
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic b_mv, b_instr, got_i, got_d, err;
    logic [8:0]  b_addr;
    logic [31:0] b_wdata, rdata;
    logic [3:0]  b_wstrb;
    int mv_cnt;

    for (int i = 0; i < 128; i++) mem_words[i] = 32'hA500_0000 | 32'(i);
    mem_words[4] = 32'h0000_0013;
    rst = 1'b1; i_valid = 1'b0; d_valid = 1'b0; i_addr = 9'h0; d_addr = 9'h0;
    d_wdata = 32'h0; d_wstrb = 4'h0; lat[0] = 1; lat[1] = 1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // single fetch
    do_req(1'b0, 9'h010, 32'h0, 4'h0, b_mv, b_instr, b_addr, b_wdata, b_wstrb, mv_cnt, got_i, got_d, err, rdata);
    check("fetch mem_valid", 32'(b_mv), 32'h1);
    check("fetch mem_instr", 32'(b_instr), 32'h1);
    check("fetch mem_addr", 32'(b_addr), 32'h010);
    check("fetch mem_wstrb", 32'(b_wstrb), 32'h0);
    check("fetch ready side", 32'({got_i, got_d}), 32'h2);
    check("fetch err", 32'(err), 32'h0);
    check("fetch rdata", rdata, 32'h0000_0013);
    check("fetch mv cycles", 32'(mv_cnt), 32'd1);

    // store
    do_req(1'b1, 9'h104, 32'hDEAD_BEEF, 4'hF, b_mv, b_instr, b_addr, b_wdata, b_wstrb, mv_cnt, got_i, got_d, err, rdata);
    check("store mem_instr", 32'(b_instr), 32'h0);
    check("store mem_addr", 32'(b_addr), 32'h104);
    check("store mem_wdata", b_wdata, 32'hDEAD_BEEF);
    check("store mem_wstrb", 32'(b_wstrb), 32'hF);
    check("store ready side", 32'({got_i, got_d}), 32'h1);
    check("store err", 32'(err), 32'h0);
    check("store rdata", rdata, 32'hA500_0041);

    // fetch while store data still sits on d_wdata: fetch bus must carry zeros
    do_req(1'b0, 9'h014, 32'h0, 4'h0, b_mv, b_instr, b_addr, b_wdata, b_wstrb, mv_cnt, got_i, got_d, err, rdata);
    check("fetch2 mem_wdata", b_wdata, 32'h0);
    check("fetch2 mem_wstrb", 32'(b_wstrb), 32'h0);
    check("fetch2 rdata", rdata, 32'hA500_0005);

    // slower load
    lat[0] = 3; lat[1] = 3;
    do_req(1'b1, 9'h0C8, 32'h0, 4'h0, b_mv, b_instr, b_addr, b_wdata, b_wstrb, mv_cnt, got_i, got_d, err, rdata);
    check("load3 mv cycles", 32'(mv_cnt), 32'd3);
    check("load3 rdata", rdata, 32'hA500_0032);
    lat[0] = 1; lat[1] = 1;

    // misaligned data, then misaligned fetch, then a normal fetch
    do_req(1'b1, 9'h0A2, 32'h0, 4'h0, b_mv, b_instr, b_addr, b_wdata, b_wstrb, mv_cnt, got_i, got_d, err, rdata);
    check("misalign mem_valid", 32'(b_mv), 32'h0);
    check("misalign mv cycles", 32'(mv_cnt), 32'd0);
    check("misalign ready side", 32'({got_i, got_d}), 32'h1);
    check("misalign err", 32'(err), 32'h1);
    check("misalign rdata", rdata, 32'h0);
    do_req(1'b0, 9'h011, 32'h0, 4'h0, b_mv, b_instr, b_addr, b_wdata, b_wstrb, mv_cnt, got_i, got_d, err, rdata);
    check("misalign fetch side", 32'({got_i, got_d, err}), 32'h5);
    do_req(1'b0, 9'h010, 32'h0, 4'h0, b_mv, b_instr, b_addr, b_wdata, b_wstrb, mv_cnt, got_i, got_d, err, rdata);
    check("after misalign fetch", 32'({got_i, got_d, err}), 32'h4);
    check("after misalign rdata", rdata, 32'h0000_0013);

    // timeout, then mem_ready on the last allowed cycle
    lat[0] = 0; lat[1] = 0;
    do_req(1'b1, 9'h020, 32'h0, 4'h0, b_mv, b_instr, b_addr, b_wdata, b_wstrb, mv_cnt, got_i, got_d, err, rdata);
    check("timeout mv cycles", 32'(mv_cnt), 32'd16);
    check("timeout side/err", 32'({got_i, got_d, err}), 32'h3);
    check("timeout rdata", rdata, 32'h0);
    lat[0] = 16; lat[1] = 16;
    do_req(1'b1, 9'h020, 32'h0, 4'h0, b_mv, b_instr, b_addr, b_wdata, b_wstrb, mv_cnt, got_i, got_d, err, rdata);
    check("late ready mv cycles", 32'(mv_cnt), 32'd16);
    check("late ready side/err", 32'({got_i, got_d, err}), 32'h2);
    check("late ready rdata", rdata, 32'hA500_0008);

    // contention from a fresh reset
    lat[0] = 1; lat[1] = 1;
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    log_en = 1'b1; i_valid = 1'b1; d_valid = 1'b1; i_addr = 9'h030; d_addr = 9'h034; d_wstrb = 4'h0;
    repeat (14) @(negedge clk);
    d_valid = 1'b0;
    repeat (6) @(negedge clk);
    i_valid = 1'b0;
    repeat (6) @(negedge clk);
    log_en = 1'b0;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    check("rr grant count", 32'(got_q0.size() >= 4), 32'h1);
    check("pri grant count", 32'(got_q1.size() >= 5), 32'h1);
    if (got_q0.size() >= 4 && got_q1.size() >= 5) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rr grant %0d", i), 32'(got_q0[i]), 32'(exp_q.pop_front()));
        check($sformatf("pri grant %0d", i), 32'(got_q1[i]), 32'h0);
      end
      check("pri grant after d drops", 32'(got_q1[got_q1.size()-1]), 32'h1);
    end

    // reset two cycles into a stalled load
    lat[0] = 0; lat[1] = 0;
    @(negedge clk); d_valid = 1'b1; d_addr = 9'h040; d_wstrb = 4'h0;
    @(negedge clk); d_valid = 1'b0;
    check("pre-reset busy", 32'(dut_mem_valid[0]), 32'h1);
    @(negedge clk); #2 rst = 1'b1;
    #1 check_all_zero("mid reset");
    @(negedge clk); rst = 1'b0; lat[0] = 1; lat[1] = 1;
    i_valid = 1'b1; d_valid = 1'b1; i_addr = 9'h044; d_addr = 9'h048;
    @(negedge clk);
    i_valid = 1'b0; d_valid = 1'b0;
    check("post-reset rr grant", 32'({dut_mem_valid[0], dut_mem_instr[0]}), 32'h3);
    check("post-reset pri grant", 32'({dut_mem_valid[1], dut_mem_instr[1]}), 32'h2);
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
